// File: rtl/move_queue_dispatcher_pkg.sv
// Shared move codes, helper functions and FSM state types for the move queue dispatcher.
package rbot_moves_pkg;

  localparam int unsigned MOVE_W = 4;
  typedef logic [MOVE_W-1:0] move_t;

  localparam move_t MOVE_NONE = 4'd0;
  localparam move_t R  = 4'd2;
  localparam move_t Ri = 4'd3;
  localparam move_t U  = 4'd4;
  localparam move_t Ui = 4'd5;
  localparam move_t F  = 4'd6;
  localparam move_t Fi = 4'd7;
  localparam move_t L  = 4'd8;
  localparam move_t Li = 4'd9;
  localparam move_t B  = 4'd10;
  localparam move_t Bi = 4'd11;
  localparam move_t D  = 4'd12;
  localparam move_t Di = 4'd13;

  typedef enum logic {
    L_IDLE,
    L_UNPACK
  } load_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ISSUE,
    D_WAIT,
    D_SETTLE
  } disp_state_t;

  function automatic logic [2:0] face(input move_t code);
    return code[3:1];
  endfunction

  // Same face, opposite turn direction.
  function automatic logic is_inverse(input move_t a, input move_t b);
    return (face(a) == face(b)) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/move_queue_dispatcher_if.sv
// Producer/stepper-facing signal bundle of the move queue dispatcher.
interface move_queue_dispatcher_if #(
  parameter int unsigned MOVE_W = 4,
  parameter int unsigned BATCH  = 50,
  parameter int unsigned CNT_W  = 8
);
  logic                      new_moves;
  logic [BATCH*MOVE_W-1:0]   seq;
  logic                      seq_complete;
  logic                      pause;
  logic                      flush;
  logic                      move_done;
  logic [MOVE_W-1:0]         next_move;
  logic                      move_start;
  logic                      load_busy;
  logic                      queue_empty;
  logic                      queue_full;
  logic                      overflow;
  logic [CNT_W-1:0]          num_moves;
  logic [CNT_W-1:0]          curr_step;
  logic                      seq_done;

  modport master (
    output new_moves, seq, seq_complete, pause, flush, move_done,
    input  next_move, move_start, load_busy, queue_empty, queue_full,
           overflow, num_moves, curr_step, seq_done
  );

  modport slave (
    input  new_moves, seq, seq_complete, pause, flush, move_done,
    output next_move, move_start, load_busy, queue_empty, queue_full,
           overflow, num_moves, curr_step, seq_done
  );
endinterface

// File: rtl/move_queue_dispatcher_fifo.sv
// move_fifo: synchronous FIFO (distributed RAM) with head pop, tail retract, clear and occupancy count.
module move_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       tail_pop,
  output logic [W-1:0]               head,
  output logic [W-1:0]               tail,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // push and tail_pop are never asserted together by the owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push) - AW'(tail_pop);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop) - CW'(tail_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - AW'(1)];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/move_queue_dispatcher.sv
// Move queue: unpacks move batches into a FIFO and issues them to the stepper one at a time.
// Optional build macro MOVE_CANCEL_EN: cancel inverse move pairs at the FIFO tail on push.
module move_queue_dispatcher
  import rbot_moves_pkg::*;
#(
  parameter int unsigned MOVE_W        = 4,
  parameter int unsigned BATCH         = 50,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 2500
) (
  input  logic                    clock,
  input  logic                    reset_n,
  move_queue_dispatcher_if.slave  bus
);
  localparam int unsigned IDX_W       = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int unsigned FCW         = $clog2(DEPTH) + 1;
  localparam int unsigned SW          = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  load_state_t                   lstate, lnext;
  logic [BATCH-1:0][MOVE_W-1:0]  seq_q;
  logic [IDX_W-1:0]              idx;
  logic [MOVE_W-1:0]             code;

  disp_state_t                   dstate, dnext;
  logic [SW-1:0]                 settle_cnt;
  logic                          armed;
  logic                          aborted;
  logic [MOVE_W-1:0]             next_move_q;
  logic [CNT_W-1:0]              num_moves_q;
  logic [CNT_W-1:0]              curr_step_q;
  logic                          overflow_q;

  logic                          have_code;
  logic                          cancel;
  logic                          push_acc;
  logic                          drop;
  logic                          pop;
  logic                          move_start;
  logic                          seq_done;
  logic [MOVE_W-1:0]             head;
  logic [MOVE_W-1:0]             tail;
  logic [FCW-1:0]                count;
  logic                          full;
  logic                          empty;

  assign code = seq_q[idx];

  // Loader FSM
  always_comb begin
    lnext = lstate;
    unique case (lstate)
      L_IDLE:   if (bus.new_moves) lnext = L_UNPACK;
      L_UNPACK: if (code == MOVE_NONE || idx == IDX_W'(BATCH - 1)) lnext = L_IDLE;
      default:  lnext = L_IDLE;
    endcase
    if (bus.flush) lnext = L_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lstate <= L_IDLE;
      seq_q  <= '0;
      idx    <= '0;
    end else begin
      lstate <= lnext;
      if (lstate == L_IDLE && bus.new_moves) begin
        seq_q <= bus.seq;
        idx   <= '0;
      end else if (lstate == L_UNPACK) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign have_code = (lstate == L_UNPACK) && !bus.flush && (code != MOVE_NONE);

`ifdef MOVE_CANCEL_EN
  // A tail that is also the head being popped this cycle is already in flight.
  assign cancel = have_code && !empty && is_inverse(move_t'(code), move_t'(tail))
                  && !(pop && count == FCW'(1));
`else
  logic unused_cancel_inputs;
  assign cancel               = 1'b0;
  assign unused_cancel_inputs = ^{tail, count};
`endif

  assign push_acc = have_code && !cancel && (!full || pop);
  assign drop     = have_code && !cancel && full && !pop;

  move_fifo #(
    .W     (MOVE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (bus.flush),
    .push      (push_acc),
    .push_data (code),
    .pop       (pop),
    .tail_pop  (cancel),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Dispatcher FSM
  always_comb begin
    dnext      = dstate;
    pop        = 1'b0;
    move_start = 1'b0;
    seq_done   = 1'b0;
    unique case (dstate)
      D_IDLE: begin
        if (!bus.flush && armed && empty && (lstate == L_IDLE) && curr_step_q != '0)
          seq_done = 1'b1;
        else if (!bus.flush && armed && !bus.pause && !empty)
          dnext = D_ISSUE;
      end
      D_ISSUE: begin
        pop        = !empty;
        move_start = 1'b1;
        dnext      = D_WAIT;
      end
      D_WAIT: begin
        if (bus.move_done) dnext = (SETTLE_CYCLES == 0) ? D_IDLE : D_SETTLE;
      end
      D_SETTLE: begin
        if (settle_cnt == SW'(SETTLE_LAST)) dnext = D_IDLE;
      end
      default: dnext = D_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dstate      <= D_IDLE;
      settle_cnt  <= '0;
      armed       <= 1'b0;
      aborted     <= 1'b0;
      next_move_q <= '0;
      num_moves_q <= '0;
      curr_step_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      dstate     <= dnext;
      settle_cnt <= (dstate == D_SETTLE) ? settle_cnt + SW'(1) : '0;
      if (dstate == D_ISSUE) next_move_q <= head;

      if (bus.flush)             armed <= 1'b0;
      else if (seq_done)         armed <= 1'b0;
      else if (bus.seq_complete) armed <= 1'b1;

      // A move flushed while in flight still completes but is not counted.
      if (dstate == D_WAIT && bus.move_done)
        aborted <= 1'b0;
      else if (bus.flush && (dstate == D_ISSUE || dstate == D_WAIT))
        aborted <= 1'b1;

      if (bus.flush)
        curr_step_q <= '0;
      else if (dstate == D_WAIT && bus.move_done && !aborted && curr_step_q != '1)
        curr_step_q <= curr_step_q + CNT_W'(1);

      if (bus.flush)
        num_moves_q <= '0;
      else if (push_acc && num_moves_q != '1)
        num_moves_q <= num_moves_q + CNT_W'(1);
      else if (cancel && num_moves_q != '0)
        num_moves_q <= num_moves_q - CNT_W'(1);

      if (bus.flush)  overflow_q <= 1'b0;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

  assign bus.next_move   = (dstate == D_ISSUE) ? head : next_move_q;
  assign bus.move_start  = move_start;
  assign bus.seq_done    = seq_done;
  assign bus.load_busy   = (lstate == L_UNPACK);
  assign bus.queue_empty = empty;
  assign bus.queue_full  = full;
  assign bus.overflow    = overflow_q;
  assign bus.num_moves   = num_moves_q;
  assign bus.curr_step   = curr_step_q;

endmodule
